// File: rtl/ws2812_rx.sv
// WS2812 single-wire receiver: times each high pulse, decodes GRB pixels MSB-first and flags latch gaps and bad pulses.
// Define WS2812_RX_SYNC_EN to put a 2-flop synchronizer on din (required when din comes from a pad).
module ws2812_rx #(
  parameter int unsigned THRESH_CYCLES   = 30,
  parameter int unsigned MIN_HIGH_CYCLES = 8,
  parameter int unsigned MAX_HIGH_CYCLES = 60,
  parameter int unsigned RESET_CYCLES    = 2500,
  parameter int unsigned IDX_W           = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din,
  output logic             pixel_valid,
  output logic [23:0]      pixel_data,
  output logic [IDX_W-1:0] pixel_index,
  output logic             frame_done,
  output logic             bit_error
);

  localparam logic [11:0]      THRESH_C = 12'(THRESH_CYCLES);
  localparam logic [11:0]      MIN_C    = 12'(MIN_HIGH_CYCLES);
  localparam logic [11:0]      MAX_C    = 12'(MAX_HIGH_CYCLES);
  localparam logic [11:0]      RESET_C  = 12'(RESET_CYCLES);
  localparam logic [11:0]      CNT_MAX  = 12'hFFF;
  localparam logic [IDX_W-1:0] IDX_MAX  = {IDX_W{1'b1}};

  typedef enum logic [1:0] {
    SYNC = 2'd0,
    LOW  = 2'd1,
    HIGH = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [11:0]      cnt_q, cnt_d;
  logic [23:0]      shift_q, shift_d;
  logic [4:0]       bit_cnt_q, bit_cnt_d;
  logic [IDX_W-1:0] pix_cnt_q, pix_cnt_d;
  logic             any_bit_q, any_bit_d;
  logic             din_p_q, din_p_d;
  logic             pixel_valid_q, pixel_valid_d;
  logic [23:0]      pixel_data_q, pixel_data_d;
  logic [IDX_W-1:0] pixel_index_q, pixel_index_d;
  logic             frame_done_q, frame_done_d;
  logic             bit_error_q, bit_error_d;

  logic             din_s;
  logic             rise;
  logic             fall;
  logic             gap;
  logic             in_range;
  logic             new_bit;
  logic [23:0]      shifted;

`ifdef WS2812_RX_SYNC_EN
  logic sync1_q;
  logic sync2_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= din;
      sync2_q <= sync1_q;
    end
  end

  assign din_s = sync2_q;
`else
  assign din_s = din;
`endif

  // cnt_q holds the length of the current level, so at a falling edge it equals the high time.
  assign rise     = din_s & ~din_p_q;
  assign fall     = ~din_s & din_p_q;
  assign gap      = ~din_s && (cnt_q == RESET_C);
  assign in_range = (cnt_q >= MIN_C) && (cnt_q <= MAX_C);
  assign new_bit  = (cnt_q >= THRESH_C);
  assign shifted  = {shift_q[22:0], new_bit};

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    shift_d       = shift_q;
    bit_cnt_d     = bit_cnt_q;
    pix_cnt_d     = pix_cnt_q;
    any_bit_d     = any_bit_q;
    din_p_d       = din_s;
    pixel_valid_d = 1'b0;
    pixel_data_d  = pixel_data_q;
    pixel_index_d = pixel_index_q;
    frame_done_d  = 1'b0;
    bit_error_d   = 1'b0;

    if (rise || fall) begin
      cnt_d = 12'd1;
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + 12'd1;
    end else begin
      cnt_d = cnt_q;
    end

    case (state_q)
      SYNC: begin
        // A clean gap re-arms the decoder but never ends a frame.
        if (gap) begin
          state_d   = LOW;
          shift_d   = 24'd0;
          bit_cnt_d = 5'd0;
          pix_cnt_d = '0;
          any_bit_d = 1'b0;
        end else begin
          state_d = SYNC;
        end
      end
      LOW: begin
        if (rise) begin
          state_d = HIGH;
        end else if (gap) begin
          frame_done_d = any_bit_q;
          shift_d      = 24'd0;
          bit_cnt_d    = 5'd0;
          pix_cnt_d    = '0;
          any_bit_d    = 1'b0;
        end else begin
          state_d = LOW;
        end
      end
      HIGH: begin
        if (fall) begin
          if (in_range) begin
            state_d   = LOW;
            any_bit_d = 1'b1;
            if (bit_cnt_q == 5'd23) begin
              pixel_valid_d = 1'b1;
              pixel_data_d  = shifted;
              pixel_index_d = pix_cnt_q;
              shift_d       = 24'd0;
              bit_cnt_d     = 5'd0;
              if (pix_cnt_q != IDX_MAX) begin
                pix_cnt_d = pix_cnt_q + IDX_W'(1);
              end else begin
                pix_cnt_d = pix_cnt_q;
              end
            end else begin
              shift_d   = shifted;
              bit_cnt_d = bit_cnt_q + 5'd1;
            end
          end else begin
            state_d     = SYNC;
            bit_error_d = 1'b1;
            shift_d     = 24'd0;
            bit_cnt_d   = 5'd0;
          end
        end else if (cnt_q > MAX_C) begin
          // Stuck-high line: report now rather than waiting for the fall.
          state_d     = SYNC;
          bit_error_d = 1'b1;
          shift_d     = 24'd0;
          bit_cnt_d   = 5'd0;
        end else begin
          state_d = HIGH;
        end
      end
      default: begin
        state_d = SYNC;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= SYNC;
      cnt_q         <= 12'd0;
      shift_q       <= 24'd0;
      bit_cnt_q     <= 5'd0;
      pix_cnt_q     <= '0;
      any_bit_q     <= 1'b0;
      din_p_q       <= 1'b0;
      pixel_valid_q <= 1'b0;
      pixel_data_q  <= 24'd0;
      pixel_index_q <= '0;
      frame_done_q  <= 1'b0;
      bit_error_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      shift_q       <= shift_d;
      bit_cnt_q     <= bit_cnt_d;
      pix_cnt_q     <= pix_cnt_d;
      any_bit_q     <= any_bit_d;
      din_p_q       <= din_p_d;
      pixel_valid_q <= pixel_valid_d;
      pixel_data_q  <= pixel_data_d;
      pixel_index_q <= pixel_index_d;
      frame_done_q  <= frame_done_d;
      bit_error_q   <= bit_error_d;
    end
  end

  assign pixel_valid = pixel_valid_q;
  assign pixel_data  = pixel_data_q;
  assign pixel_index = pixel_index_q;
  assign frame_done  = frame_done_q;
  assign bit_error   = bit_error_q;

endmodule

// File: tb/tb_ws2812_rx.sv
// Bench for ws2812_rx: pulse-level reference model with randomized bit timing; din is driven and outputs sampled on the falling clock edge.
module tb_ws2812_rx;

  localparam int RST_GAP = 2500;
`ifdef WS2812_RX_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        din = 1'b0;
  logic        pixel_valid;
  logic [23:0] pixel_data;
  logic [7:0]  pixel_index;
  logic        frame_done;
  logic        bit_error;

  ws2812_rx dut (
    .clk         (clk),
    .rst         (rst),
    .din         (din),
    .pixel_valid (pixel_valid),
    .pixel_data  (pixel_data),
    .pixel_index (pixel_index),
    .frame_done  (frame_done),
    .bit_error   (bit_error)
  );

  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;
  int cyc        = 0;

  // observed events
  logic [23:0] act_d[$];
  int          act_i[$];
  int          act_c[$];
  int          act_fd[$];
  int          act_be = 0;
  int          coinc  = 0;

  // expected events
  logic [23:0] exp_d[$];
  int          exp_i[$];
  int          exp_c[$];
  int          exp_fd[$];
  int          exp_be = 0;

  // reference model state
  bit          m_sync = 1'b0;
  int          m_acc = 0;
  int          m_nbits = 0;
  int          m_idx = 0;
  bit          m_any = 1'b0;
  int          m_last_fall = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    compared++;
    assert (obs === expv)
    else begin
      mismatched++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  task automatic model_clear();
    m_acc   = 0;
    m_nbits = 0;
    m_idx   = 0;
    m_any   = 1'b0;
  endtask

  // One high of h cycles followed by l (>=1) low cycles, then the model's view of that pulse.
  task automatic send_pulse(input int h, input int l);
    int fall;
    repeat (h) begin
      @(negedge clk);
      din = 1'b1;
    end
    @(negedge clk);
    din  = 1'b0;
    fall = cyc;
    repeat (l - 1) @(negedge clk);
    if (m_sync) begin
      m_last_fall = fall;
      if (h < 8 || h > 60) begin
        exp_be++;
        m_sync  = 1'b0;
        m_acc   = 0;
        m_nbits = 0;
      end else begin
        m_acc = ((m_acc << 1) | ((h >= 30) ? 1 : 0)) & 32'h00FF_FFFF;
        m_nbits++;
        m_any = 1'b1;
        if (m_nbits == 24) begin
          exp_d.push_back(m_acc[23:0]);
          exp_i.push_back(m_idx);
          exp_c.push_back(fall + LAT);
          if (m_idx < 255) m_idx++;
          m_nbits = 0;
          m_acc   = 0;
        end
      end
    end
  endtask

  // mode 0: 40/20 high, 25 low; mode 1: randomized legal timing; mode 2: fastest legal timing
  task automatic send_pixel(input logic [23:0] data, input int mode);
    int h;
    int l;
    for (int i = 23; i >= 0; i--) begin
      case (mode)
        0: begin
          h = data[i] ? 40 : 20;
          l = 25;
        end
        1: begin
          h = data[i] ? int'($urandom_range(34, 30)) : int'($urandom_range(12, 8));
          l = int'($urandom_range(3, 1));
        end
        default: begin
          h = data[i] ? 30 : 8;
          l = 1;
        end
      endcase
      send_pulse(h, l);
    end
  endtask

  task automatic send_bits(input int n);
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(1, 0) == 1) send_pulse(int'($urandom_range(45, 30)), int'($urandom_range(4, 1)));
      else send_pulse(int'($urandom_range(29, 8)), int'($urandom_range(4, 1)));
    end
  endtask

  task automatic send_gap(input int n);
    repeat (n) begin
      @(negedge clk);
      din = 1'b0;
    end
    if (m_sync) begin
      if (m_any) exp_fd.push_back(m_last_fall + LAT + RST_GAP);
    end else begin
      m_sync = 1'b1;
    end
    model_clear();
  endtask

  task automatic do_reset(input int n, input string pre);
    @(negedge clk);
    rst = 1'b1;
    din = 1'b0;
    repeat (n) @(negedge clk);
    check({pre, " pixel_valid"}, 32'(pixel_valid), 32'd0);
    check({pre, " pixel_data"},  32'(pixel_data),  32'd0);
    check({pre, " pixel_index"}, 32'(pixel_index), 32'd0);
    check({pre, " frame_done"},  32'(frame_done),  32'd0);
    check({pre, " bit_error"},   32'(bit_error),   32'd0);
    rst    = 1'b0;
    m_sync = 1'b0;
    model_clear();
  endtask

  task automatic compare_all(input string pre);
    while (exp_d.size() > 0) begin
      logic [23:0] ed;
      int          ei;
      int          ec;
      ed = exp_d.pop_front();
      ei = exp_i.pop_front();
      ec = exp_c.pop_front();
      if (act_d.size() == 0) begin
        check({pre, " pixel count short"}, 32'(act_d.size()), 32'd1);
      end else begin
        check({pre, " pixel_data"},  32'(act_d.pop_front()), 32'(ed));
        check({pre, " pixel_index"}, 32'(act_i.pop_front()), 32'(ei));
        check({pre, " pixel cycle"}, 32'(act_c.pop_front()), 32'(ec));
      end
    end
    check({pre, " extra pixels"}, 32'(act_d.size()), 32'd0);
    while (act_d.size() > 0) begin
      void'(act_d.pop_front());
      void'(act_i.pop_front());
      void'(act_c.pop_front());
    end
    while (exp_fd.size() > 0) begin
      int ef;
      ef = exp_fd.pop_front();
      if (act_fd.size() == 0) check({pre, " frame_done count short"}, 32'(act_fd.size()), 32'd1);
      else check({pre, " frame_done cycle"}, 32'(act_fd.pop_front()), 32'(ef));
    end
    check({pre, " extra frame_done"}, 32'(act_fd.size()), 32'd0);
    while (act_fd.size() > 0) void'(act_fd.pop_front());
    check({pre, " bit_error count"}, 32'(act_be), 32'(exp_be));
  endtask

  initial begin
    fork
      forever begin
        @(posedge clk);
        cyc++;
      end
      forever begin
        @(negedge clk);
        if (pixel_valid === 1'b1) begin
          act_d.push_back(pixel_data);
          act_i.push_back(int'(pixel_index));
          act_c.push_back(cyc);
        end
        if (frame_done === 1'b1) act_fd.push_back(cyc);
        if (bit_error === 1'b1) act_be++;
        if (pixel_valid === 1'b1 && (frame_done === 1'b1 || bit_error === 1'b1)) coinc++;
      end
    join_none

    // reset and initial sync: nothing may strobe
    do_reset(3, "reset");
    send_gap(2600);
    compare_all("sync");
    check("sync pixel_data", 32'(pixel_data), 32'd0);
    check("sync pixel_index", 32'(pixel_index), 32'd0);

    // single pixel at nominal timing, then a gap ending that frame
    send_pixel(24'hA5F00F, 0);
    send_gap(2600);
    compare_all("single");
    check("single data held", 32'(pixel_data), 32'h00A5_F00F);

    // three-pixel frame; indices restart after the gap
    send_pixel(24'h112233, 1);
    send_pixel(24'h445566, 1);
    send_pixel(24'hFFFFFF, 1);
    send_gap(2600);
    compare_all("frame");

    // threshold and range boundaries, then a too-short pulse
    send_pulse(29, 3);
    send_pulse(30, 3);
    send_pulse(8, 2);
    send_pulse(60, 2);
    send_bits(20);
    send_bits(5);
    send_pulse(7, 3);
    send_bits(24);
    send_gap(2600);
    compare_all("short");

    // partial frame, then a full pixel, then reset mid-pixel
    send_bits(10);
    send_gap(2600);
    compare_all("partial");
    send_pixel(24'($urandom) | 24'h000001, 1);
    send_bits(12);
    do_reset(2, "midreset");
    send_bits(12);
    send_gap(2600);
    compare_all("midreset");

    // 300-pixel frame: index saturates at 255
    for (int k = 0; k < 300; k++) begin
      send_pixel((k % 50 == 7) ? 24'($urandom) : 24'h000000, 2);
    end
    send_gap(2600);
    compare_all("long frame");

    // too-long pulse, decoding stays off afterwards
    send_bits(3);
    send_pulse(61, 3);
    send_bits(24);
    repeat (20) @(negedge clk);
    compare_all("toolong");
    check("strobe coincidence", 32'(coinc), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/ws2812_rx.md
# ws2812_rx

- Receives and decodes a WS2812 single-wire serial LED stream into 24-bit GRB pixel words.
- Serves as the receiving end of the racer's LED-strip output: it loops back and checks the frames the game drives to the strip, and can also accept a stream from an upstream controller.
- Measures each high pulse to classify bits, assembles pixels MSB-first, counts pixels within a frame, and flags latch (reset) gaps and malformed pulses.

## Interface

Parameters:
- `THRESH_CYCLES`, 30 — high length at or above this count decodes as 1, below it as 0 (50 MHz: T0H 20, T1H 40).
- `MIN_HIGH_CYCLES`, 8 — shortest legal high pulse.
- `MAX_HIGH_CYCLES`, 60 — longest legal high pulse.
- `RESET_CYCLES`, 2500 — low length that constitutes a latch gap (50 µs at 50 MHz).
- `IDX_W`, 8 — pixel index width.

Ports:
- `clk` input 1 — the single clock; everything is clocked on its rising edge.
- `rst` input 1 — synchronous reset, active high.
- `din` input 1 — WS2812 serial data in, asynchronous to `clk`.
- `pixel_valid` output 1 — one-cycle strobe: a complete pixel is on `pixel_data`/`pixel_index`.
- `pixel_data` output 24 — last decoded pixel; the first bit received is in bit 23.
- `pixel_index` output IDX_W — position of that pixel in the frame (0 = first).
- `frame_done` output 1 — one-cycle strobe when a latch gap ends a non-empty frame.
- `bit_error` output 1 — one-cycle strobe when a high pulse is out of range.

## Operation

Input stage:
- `din_s` is the sampled input and `din_p` is `din_s` delayed by one cycle.
- A rising edge is `din_s=1` with `din_p=0`; a falling edge is `din_s=0` with `din_p=1`.
- Level counter `cnt` (12 bits, saturating at 4095):
  - loads 1 on every edge;
  - increments while the level is unchanged.

State machine `SYNC`, `LOW`, `HIGH`:
- **Reset** → `SYNC`. All outputs are 0; `cnt`, the 24-bit shift register, `bit_cnt` (0..23), the pixel counter and `din_p` are all 0.
- **SYNC** — wait for a clean gap:
  - any `din_s=1` holds the state;
  - when `din_s=0` and `cnt` reaches `RESET_CYCLES` → `LOW`, with no `frame_done`.
- **LOW**:
  - rising edge → `HIGH`;
  - when `cnt` reaches `RESET_CYCLES` (exactly once per gap): discard any partial pixel, clear `bit_cnt` and the pixel counter, stay in `LOW`;
  - on that same event, pulse `frame_done` only if at least one bit was received since the previous gap.
- **HIGH**:
  - falling edge, where H is the `cnt` value in the cycle before the edge:
    - if `MIN_HIGH_CYCLES` ≤ H ≤ `MAX_HIGH_CYCLES`: shift bit (H ≥ `THRESH_CYCLES`) into the LSB, `bit_cnt`+1, → `LOW`;
    - otherwise: pulse `bit_error`, discard the partial pixel, → `SYNC`.
  - If `cnt` exceeds `MAX_HIGH_CYCLES` while still high: pulse `bit_error` immediately, → `SYNC`.
- **Pixel complete** (24th valid bit):
  - `pixel_data` ← shift register, `pixel_index` ← pixel counter, `pixel_valid`=1;
  - then the pixel counter increments, saturating at 2^IDX_W−1, and `bit_cnt` ← 0.
- The low time between bits is not checked, other than for the latch gap.
- `pixel_data`/`pixel_index` hold their values between strobes.
- `rst` has priority over every event in the same cycle.

## Timing

- Outputs are registered; every strobe lasts exactly 1 cycle.
- `pixel_valid`/`bit_error` (range case) assert in the cycle after the falling edge is detected on `din_s`.
- `din` falling to `pixel_valid` takes 3 cycles with the synchronizer and 1 cycle without it.
- `frame_done` asserts in the cycle after `cnt` reaches `RESET_CYCLES`; this is `RESET_CYCLES`+1 cycles after the last falling edge on `din_s`.
- Minimum spacing between pixel strobes is 24×(`MIN_HIGH_CYCLES`+1) cycles.
- `frame_done` and `pixel_valid` can never coincide; `bit_error` and `pixel_valid` can never coincide.
- Reset mid-pixel drops the partial pixel. No output strobes until the next full `RESET_CYCLES` gap after leaving `SYNC`.

## Configuration

- `WS2812_RX_SYNC_EN` defined: `din` passes through a 2-flop synchronizer before `din_s` (2 cycles added latency). Use this whenever `din` comes from a pad.
- Undefined: `din_s` = `din` sampled directly. Legal only when `din` is driven from logic on `clk`, such as on-chip loopback. All latencies shrink by 2 cycles.

## Test plan

All values at default parameters; the bench defines `WS2812_RX_SYNC_EN`.

- **Reset/sync:** `rst` 3 cycles, `din`=0 for 2600 cycles → all outputs 0 throughout, no `frame_done`.
- **Single pixel:** after sync, send 24 bits of 0xA5F00F (high 40/20 cycles, low 25) → one `pixel_valid`, data 0xA5F00F, index 0, 3 cycles after the last `din` fall.
- **Frame:** 3 pixels 0x112233, 0x445566, 0xFFFFFF, then low 2600 → indices 0, 1, 2; `frame_done` once; the next frame restarts at index 0.
- **Threshold edges:** highs of 29 and 30 cycles decode as 0 and 1; highs of 7 and 61 → `bit_error`, no `pixel_valid`, and no decode until the next full gap.
- **Partial frame:** 10 bits then a 2600-cycle gap → `frame_done`, no `pixel_valid`. The following 24 bits decode correctly at index 0.
- **Reset mid-pixel:** `rst` pulsed after 12 bits → outputs 0, remaining bits ignored until a gap; index saturates at 255 in a 300-pixel frame.
